// File: rtl/controle_relogio.sv
// ---------------------------------------------------------------------------
// controle_relogio -- turn controller for the chess clock.
//
// Sits upstream of the two per-player time counters (branco, preto). It divides
// the system clock into a time-base tick, routes the tick to the player whose
// turn it is, and reacts to the start, move and pause buttons. The game stops
// when the active player's counter raises fim.
//
// Parameters:
//   TICK_DIV  system clocks per time-base tick (>= 2)
//   DIV_W     divider width, 2**DIV_W >= TICK_DIV
//
// Ports:
//   clock                    system clock, rising edge
//   reset                    asynchronous, active-high reset
//   iniciar, jogada, pausa   start / move-done / pause buttons (levels)
//   fim_b, fim_p             time-out flags from the branco / preto counters
//   zera_s                   clear strobe to both counters (PREPARA cycle)
//   conta_b, conta_p         one-cycle count strobes
//   decresce_b, decresce_p   one-cycle adjustment strobes
//   vez                      turn: 0 = branco, 1 = preto
//   acabou                   game over
//   perdedor                 flagged player, valid while acabou = 1
//   estado                   FSM state, for debug
//
// Build option:
//   CONTROLE_INCREMENTO_EN   when defined, each turn switch pulses decresce_*
//                            for the player who just moved; otherwise the
//                            decresce_* outputs are tied to 0.
// ---------------------------------------------------------------------------
module controle_relogio #(
    parameter int TICK_DIV = 50000,
    parameter int DIV_W    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       pausa,
    input  logic       fim_b,
    input  logic       fim_p,
    output logic       zera_s,
    output logic       conta_b,
    output logic       conta_p,
    output logic       decresce_b,
    output logic       decresce_p,
    output logic       vez,
    output logic       acabou,
    output logic       perdedor,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        INICIAL    = 3'd0,
        PREPARA    = 3'd1,
        VEZ_BRANCO = 3'd2,
        VEZ_PRETO  = 3'd3,
        PAUSADO    = 3'd4,
        FIM        = 3'd5
    } estado_t;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    estado_t          estado_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             div_wrap;
    logic             vez_q;
    logic             perdedor_q;
    logic             acabou_q;
    logic             zera_s_q;
    logic             conta_b_q;
    logic             conta_p_q;

    // One register stage per button plus a delayed copy for edge detection.
    logic ini_q, ini_prev_q;
    logic jog_q, jog_prev_q;
    logic pau_q, pau_prev_q;
    logic ini_ev, jog_ev, pau_ev;
    logic fim_ativo;

    assign ini_ev = ini_q & ~ini_prev_q;
    assign jog_ev = jog_q & ~jog_prev_q;
    assign pau_ev = pau_q & ~pau_prev_q;

    // Only the active player's fim matters; the other one is ignored.
    assign fim_ativo = vez_q ? fim_p : fim_b;

    assign div_wrap = (div_q == DIV_MAX);
    assign div_d    = div_wrap ? '0 : div_q + 1'b1;

`ifdef CONTROLE_INCREMENTO_EN
    logic decresce_b_q;
    logic decresce_p_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= INICIAL;
            div_q      <= '0;
            vez_q      <= 1'b0;
            perdedor_q <= 1'b0;
            acabou_q   <= 1'b0;
            zera_s_q   <= 1'b0;
            conta_b_q  <= 1'b0;
            conta_p_q  <= 1'b0;
            ini_q      <= 1'b0;
            ini_prev_q <= 1'b0;
            jog_q      <= 1'b0;
            jog_prev_q <= 1'b0;
            pau_q      <= 1'b0;
            pau_prev_q <= 1'b0;
`ifdef CONTROLE_INCREMENTO_EN
            decresce_b_q <= 1'b0;
            decresce_p_q <= 1'b0;
`endif
        end else begin
            ini_q      <= iniciar;
            ini_prev_q <= ini_q;
            jog_q      <= jogada;
            jog_prev_q <= jog_q;
            pau_q      <= pausa;
            pau_prev_q <= pau_q;

            // Strobes are single-cycle: default low, raised below.
            zera_s_q  <= 1'b0;
            conta_b_q <= 1'b0;
            conta_p_q <= 1'b0;
`ifdef CONTROLE_INCREMENTO_EN
            decresce_b_q <= 1'b0;
            decresce_p_q <= 1'b0;
`endif

            case (estado_q)
                INICIAL: begin
                    if (ini_ev) begin
                        estado_q <= PREPARA;
                        zera_s_q <= 1'b1;
                    end
                end

                PREPARA: begin
                    estado_q <= VEZ_BRANCO;
                    vez_q    <= 1'b0;
                    div_q    <= '0;
                end

                VEZ_BRANCO, VEZ_PRETO: begin
                    if (fim_ativo) begin
                        // Time-out wins over everything and suppresses the tick.
                        estado_q   <= FIM;
                        acabou_q   <= 1'b1;
                        perdedor_q <= vez_q;
                    end else begin
                        div_q <= div_d;
                        // A wrap is credited to the player active in this cycle,
                        // even when a move switches the turn at the same edge.
                        if (div_wrap) begin
                            if (vez_q) conta_p_q <= 1'b1;
                            else       conta_b_q <= 1'b1;
                        end
                        if (pau_ev) begin
                            estado_q <= PAUSADO;
                        end else if (jog_ev) begin
                            estado_q <= vez_q ? VEZ_BRANCO : VEZ_PRETO;
                            vez_q    <= ~vez_q;
`ifdef CONTROLE_INCREMENTO_EN
                            if (vez_q) decresce_p_q <= 1'b1;
                            else       decresce_b_q <= 1'b1;
`endif
                        end
                    end
                end

                PAUSADO: begin
                    // Divider holds its value; moves are ignored while paused.
                    if (pau_ev) begin
                        estado_q <= vez_q ? VEZ_PRETO : VEZ_BRANCO;
                    end
                end

                FIM: begin
                    if (ini_ev) begin
                        estado_q <= PREPARA;
                        zera_s_q <= 1'b1;
                        acabou_q <= 1'b0;
                    end
                end

                default: begin
                    estado_q <= INICIAL;
                    acabou_q <= 1'b0;
                end
            endcase
        end
    end

    assign zera_s   = zera_s_q;
    assign conta_b  = conta_b_q;
    assign conta_p  = conta_p_q;
    assign vez      = vez_q;
    assign acabou   = acabou_q;
    assign perdedor = perdedor_q;
    assign estado   = estado_q;

`ifdef CONTROLE_INCREMENTO_EN
    assign decresce_b = decresce_b_q;
    assign decresce_p = decresce_p_q;
`else
    assign decresce_b = 1'b0;
    assign decresce_p = 1'b0;
`endif

endmodule

// File: tb/tb_controle_relogio.sv
`timescale 1ns/1ps
module tb_controle_relogio;

    localparam int TICK = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar, jogada, pausa, fim_b, fim_p;
    logic       zera_s, conta_b, conta_p, decresce_b, decresce_p;
    logic       vez, acabou, perdedor;
    logic [2:0] estado;

    controle_relogio #(.TICK_DIV(TICK), .DIV_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .jogada     (jogada),
        .pausa      (pausa),
        .fim_b      (fim_b),
        .fim_p      (fim_p),
        .zera_s     (zera_s),
        .conta_b    (conta_b),
        .conta_p    (conta_p),
        .decresce_b (decresce_b),
        .decresce_p (decresce_p),
        .vez        (vez),
        .acabou     (acabou),
        .perdedor   (perdedor),
        .estado     (estado)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: game phase, turn, and total cycles of active play
    // since the last PREPARA; a tick is due whenever that total reaches a
    // multiple of TICK.
    // ------------------------------------------------------------------
    int   m_fase;
    int   m_jogado;
    logic m_vez, m_perd, m_acabou, m_zera, m_cb, m_cp, m_db, m_dp;
    logic [2:0] m_bt, m_bt_prev;      // {iniciar, jogada, pausa}
    logic ev_i, ev_j, ev_p, m_fim;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_fase = 0; m_jogado = 0; m_vez = 0; m_perd = 0; m_acabou = 0;
            m_zera = 0; m_cb = 0; m_cp = 0; m_db = 0; m_dp = 0;
            m_bt = 3'b000; m_bt_prev = 3'b000;
        end else begin
            ev_i = m_bt[2] & ~m_bt_prev[2];
            ev_j = m_bt[1] & ~m_bt_prev[1];
            ev_p = m_bt[0] & ~m_bt_prev[0];
            m_zera = 0; m_cb = 0; m_cp = 0; m_db = 0; m_dp = 0;
            case (m_fase)
                0: if (ev_i) begin m_fase = 1; m_zera = 1; end
                1: begin m_fase = 2; m_vez = 0; m_jogado = 0; end
                2, 3: begin
                    m_fim = m_vez ? fim_p : fim_b;
                    if (m_fim) begin
                        m_fase = 5; m_acabou = 1; m_perd = m_vez;
                    end else begin
                        m_jogado++;
                        if (m_jogado % TICK == 0) begin
                            if (m_vez) m_cp = 1; else m_cb = 1;
                        end
                        if (ev_p) m_fase = 4;
                        else if (ev_j) begin
`ifdef CONTROLE_INCREMENTO_EN
                            if (m_vez) m_dp = 1; else m_db = 1;
`endif
                            m_vez  = ~m_vez;
                            m_fase = m_vez ? 3 : 2;
                        end
                    end
                end
                4: if (ev_p) m_fase = m_vez ? 3 : 2;
                5: if (ev_i) begin m_fase = 1; m_zera = 1; m_acabou = 0; end
                default: m_fase = 0;
            endcase
            m_bt_prev = m_bt;
            m_bt      = {iniciar, jogada, pausa};
        end
    end

    always @(negedge clock) begin
        if (chk_en && !reset) begin
            chk("estado",     estado,     m_fase);
            chk("zera_s",     zera_s,     m_zera);
            chk("conta_b",    conta_b,    m_cb);
            chk("conta_p",    conta_p,    m_cp);
            chk("decresce_b", decresce_b, m_db);
            chk("decresce_p", decresce_p, m_dp);
            chk("vez",        vez,        m_vez);
            chk("acabou",     acabou,     m_acabou);
            if (m_acabou) chk("perdedor", perdedor, m_perd);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_estado(input int tgt, input int budget);
        int k;
        k = 0;
        while (estado != 3'(tgt) && k < budget) begin
            step(1);
            k++;
        end
        chk("wait_estado", estado, tgt);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_estado"}, estado, 0);
        chk({tag, "_strobes"}, {zera_s, conta_b, conta_p, decresce_b, decresce_p}, 0);
        chk({tag, "_flags"}, {vez, acabou, perdedor}, 0);
    endtask

    int cnt_b, cnt_p, cnt_d, cnt_sw, k;
    logic vez_prev;

    initial begin
        reset = 1'b1; iniciar = 0; jogada = 0; pausa = 0; fim_b = 0; fim_p = 0;
        step(2);
        chk_all_zero("reset");
        reset = 1'b0;
        chk_en = 1'b1;
        step(2);

        // Start: zera_s for one cycle, then branco ticks every TICK cycles.
        iniciar = 1;
        step(1); chk("ini_lat_estado", estado, 0);
        step(1); chk("prep_estado", estado, 1); chk("prep_zera", zera_s, 1);
        iniciar = 0;
        step(1); chk("vb_estado", estado, 2); chk("vb_zera", zera_s, 0);
        step(3); chk("pre_tick", conta_b, 0);
        step(1); chk("first_tick", conta_b, 1);
        cnt_b = 0; cnt_p = 0;
        for (int i = 0; i < 12; i++) begin
            step(1); cnt_b += conta_b; cnt_p += conta_p;
        end
        chk("ticks_b_12", cnt_b, 3);
        chk("ticks_p_12", cnt_p, 0);

        // Held jogada: exactly one switch.
        step(10);
        jogada = 1; cnt_d = 0; cnt_sw = 0; vez_prev = vez;
        for (int i = 0; i < 20; i++) begin
            step(1);
            cnt_d += decresce_b;
            if (vez != vez_prev) cnt_sw++;
            vez_prev = vez;
        end
        jogada = 0;
        chk("held_switches", cnt_sw, 1);
        chk("held_vez", vez, 1);
        chk("held_estado", estado, 3);
`ifdef CONTROLE_INCREMENTO_EN
        chk("held_decresce_b", cnt_d, 1);
`else
        chk("held_decresce_b", cnt_d, 0);
`endif
        cnt_p = 0;
        for (int i = 0; i < 8; i++) begin step(1); cnt_p += conta_p; end
        chk("ticks_p_8", cnt_p, 2);

        // Pause with the divider at 2, resume 50 cycles later.
        k = 0;
        while (!conta_p && k < 10) begin step(1); k++; end
        chk("sync_conta_p", conta_p, 1);
        pausa = 1;
        step(2); chk("paused_estado", estado, 4);
        pausa = 0;
        cnt_b = 0;
        for (int i = 0; i < 50; i++) begin step(1); cnt_b += conta_b + conta_p; end
        chk("paused_ticks", cnt_b, 0);
        pausa = 1;
        step(2); chk("resume_estado", estado, 3);
        pausa = 0;
        step(1); chk("resume_tick_early", conta_p, 0);
        step(1); chk("resume_tick", conta_p, 1);

        // Inactive fim ignored, active fim ends the game.
        fim_b = 1;
        step(3); chk("fim_b_ignored", estado, 3); chk("fim_b_acabou", acabou, 0);
        fim_b = 0; fim_p = 1;
        step(1);
        chk("fim_estado", estado, 5); chk("fim_acabou", acabou, 1);
        chk("fim_perdedor", perdedor, 1); chk("model_fim", m_fase, 5);
        fim_p = 0;
        cnt_b = 0;
        for (int i = 0; i < 8; i++) begin step(1); cnt_b += conta_b + conta_p; end
        chk("fim_no_ticks", cnt_b, 0);
        chk("fim_hold", estado, 5);

        // Restart, then jogada and pausa together: pause wins.
        iniciar = 1; step(1); iniciar = 0;
        wait_estado(2, 10);
        chk("restart_vez", vez, 0);
        jogada = 1; pausa = 1;
        step(2); chk("both_estado", estado, 4); chk("both_vez", vez, 0);
        jogada = 0; pausa = 0;
        step(3); chk("both_hold", estado, 4);
        pausa = 1; step(2); chk("both_resume", estado, 2);
        pausa = 0;

        // Asynchronous reset mid VEZ_PRETO.
        jogada = 1; step(2); chk("pre_rst_estado", estado, 3);
        jogada = 0; step(3);
        #2 reset = 1;
        #1 chk_all_zero("async_rst");
        @(posedge clock); #1 reset = 0;
        iniciar = 1; step(1); iniciar = 0;
        wait_estado(2, 10);
        chk("post_rst_vez", vez, 0);

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0)  iniciar = ~iniciar;
            if ($urandom_range(0, 5) == 0)  jogada  = ~jogada;
            if ($urandom_range(0, 9) == 0)  pausa   = ~pausa;
            fim_b = ($urandom_range(0, 149) == 0);
            fim_p = ($urandom_range(0, 149) == 0);
            step(1);
        end
        iniciar = 0; jogada = 0; pausa = 0; fim_b = 0; fim_p = 0;
        step(5);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
